// File: rtl/vcpu_mul_unit_if.sv
// Toggle req/ack handshake bundle between the vcpu decode stage and the
// iterative multiply unit.
interface vcpu_mul_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            req;
    logic [1:0]      op;
    logic [XLEN-1:0] n;
    logic [XLEN-1:0] m;
    logic            ack;
    logic [XLEN-1:0] d;
    logic            busy;

    modport master (output req, op, n, m, input ack, d, busy);
    modport slave  (input req, op, n, m, output ack, d, busy);
endinterface

// File: rtl/vcpu_mul_unit.sv
// Iterative radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU
// family; fixed latency, result returned through the toggle req/ack handshake.
module vcpu_mul_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic           sck,
    input  logic           rst,
    vcpu_mul_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e            state_q;
    logic              req_q;
    logic              ack_q;
    logic              busy_q;
    logic              sign_q;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   d_q;
    logic [XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     count_q;

    logic              n_neg;
    logic              m_neg;
    logic [XLEN-1:0]   n_abs;
    logic [XLEN-1:0]   m_abs;
    logic [XLEN:0]     sum_d;
    logic [2*XLEN-1:0] acc_step_d;
    logic [2*XLEN-1:0] acc_fin_d;

    // n is signed for MULH/MULHSU, m only for MULH.
    always_comb begin
        n_neg = bus.n[XLEN-1] & (bus.op == 2'b01 || bus.op == 2'b10);
        m_neg = bus.m[XLEN-1] & (bus.op == 2'b01);
        n_abs = n_neg ? (XLEN'(0) - bus.n) : bus.n;
        m_abs = m_neg ? (XLEN'(0) - bus.m) : bus.m;
    end

    // Keep the carry out of the upper-half add; it re-enters at the MSB on the shift.
    always_comb begin
        sum_d = {1'b0, acc_q[2*XLEN-1:XLEN]};
        if (acc_q[0]) begin
            sum_d = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
        end
        acc_step_d = {sum_d, acc_q[XLEN-1:1]};
        acc_fin_d  = sign_q ? ((2*XLEN)'(0) - acc_q) : acc_q;
    end

    always_ff @(posedge sck) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            sign_q  <= 1'b0;
            op_q    <= '0;
            d_q     <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req != ack_q) begin
                        op_q    <= bus.op;
                        req_q   <= bus.req;
                        sign_q  <= n_neg ^ m_neg;
                        mcand_q <= n_abs;
                        acc_q   <= {{XLEN{1'b0}}, m_abs};
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q   <= acc_step_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(XLEN - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    acc_q   <= acc_fin_d;
                    d_q     <= (op_q == 2'b00) ? acc_fin_d[XLEN-1:0]
                                               : acc_fin_d[2*XLEN-1:XLEN];
                    ack_q   <= req_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ack  = ack_q;
    assign bus.d    = d_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_vcpu_mul_unit.sv
// Scoreboard bench for vcpu_mul_unit: expected products from a wide-multiply
// reference model are queued at issue and compared whenever ack toggles.
module tb_vcpu_mul_unit;
    localparam int unsigned XLEN = 32;

    logic sck = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [XLEN-1:0] exp_q[$];
    logic prev_ack = 1'b0;

    vcpu_mul_unit_if #(.XLEN(XLEN)) bus ();

    vcpu_mul_unit #(.XLEN(XLEN)) u_dut (
        .sck (sck),
        .rst (rst),
        .bus (bus)
    );

    always #5 sck = ~sck;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] model(input logic [1:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Output side of the scoreboard: every ack toggle retires the oldest entry.
    always @(negedge sck) begin
        if (rst) begin
            exp_q.delete();
            prev_ack = 1'b0;
        end else if (bus.ack !== prev_ack) begin
            if (exp_q.size() == 0) begin
                check("ack_spurious", 64'(bus.ack), 64'(prev_ack));
            end else begin
                check("sb_d", 64'(bus.d), 64'(exp_q.pop_front()));
            end
            prev_ack = bus.ack;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        bus.op  = op;
        bus.n   = a;
        bus.m   = b;
        exp_q.push_back(model(op, a, b));
        bus.req = ~bus.req;
    endtask

    // Counts edges from the req flip until ack matches, noting whether busy held.
    task automatic wait_done(output int edges, output logic busy_ok);
        edges   = 0;
        busy_ok = 1'b1;
        while (edges < 200) begin
            @(posedge sck);
            #1;
            edges++;
            if (bus.ack == bus.req) break;
            if (!bus.busy) busy_ok = 1'b0;
        end
        if (bus.ack != bus.req) check("timeout", 64'(bus.ack), 64'(bus.req));
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int   edges;
        logic bok;
        issue(op, a, b);
        wait_done(edges, bok);
        check({tag, "_lat"}, 64'(edges), 64'(XLEN + 2));
        check({tag, "_d"}, 64'(bus.d), 64'(model(op, a, b)));
    endtask

    initial begin
        int              edges;
        logic            bok;
        logic            ack0;
        logic [XLEN-1:0] d0;

        rst     = 1'b1;
        bus.req = 1'b0;
        bus.op  = '0;
        bus.n   = '0;
        bus.m   = '0;
        repeat (3) @(posedge sck);
        #1;
        rst = 1'b0;
        check("rst_ack", 64'(bus.ack), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_d", 64'(bus.d), 64'(0));

        issue(2'b00, 32'd7, 32'd6);
        wait_done(edges, bok);
        check("mul_lat", 64'(edges), 64'(34));
        check("mul_busy_held", 64'(bok), 64'(1));
        check("mul_busy_clr", 64'(bus.busy), 64'(0));
        check("mul_ack", 64'(bus.ack), 64'(1));
        check("mul_d", 64'(bus.d), 64'h2A);

        run_op("min_mulh",   2'b01, 32'h8000_0000, 32'h8000_0000);
        check("min_mulh_c", 64'(bus.d), 64'h4000_0000);
        run_op("min_mul",    2'b00, 32'h8000_0000, 32'h8000_0000);
        check("min_mul_c", 64'(bus.d), 64'h0);
        run_op("min_mulhu",  2'b11, 32'h8000_0000, 32'h8000_0000);
        check("min_mulhu_c", 64'(bus.d), 64'h4000_0000);
        run_op("ones_mulh",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("ones_mulh_c", 64'(bus.d), 64'h0);
        run_op("ones_mulhsu",2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("ones_mulhsu_c", 64'(bus.d), 64'hFFFF_FFFF);
        run_op("ones_mulhu", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("ones_mulhu_c", 64'(bus.d), 64'hFFFF_FFFE);
        run_op("ones_mul",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("ones_mul_c", 64'(bus.d), 64'h1);

        // Operand churn right after capture, then back-to-back reissue on the ack edge.
        issue(2'b00, 32'd3, 32'd5);
        @(posedge sck);
        @(posedge sck);
        #1;
        bus.n  = $urandom;
        bus.m  = $urandom;
        bus.op = 2'($urandom_range(0, 3));
        wait_done(edges, bok);
        check("churn_d", 64'(bus.d), 64'd15);
        issue(2'b00, 32'h0000_FFFF, 32'h0001_0001);
        wait_done(edges, bok);
        check("b2b_lat", 64'(edges), 64'(34));
        check("b2b_d", 64'(bus.d), 64'hFFFF_FFFF);

        issue(2'b11, 32'hFFFF_FFFF, 32'd2);
        repeat (11) @(posedge sck);
        #1;
        rst     = 1'b1;
        bus.req = 1'b0;
        @(posedge sck);
        #1;
        check("mid_rst_ack", 64'(bus.ack), 64'(0));
        check("mid_rst_busy", 64'(bus.busy), 64'(0));
        check("mid_rst_d", 64'(bus.d), 64'(0));
        rst = 1'b0;
        @(posedge sck);
        #1;
        run_op("post_rst", 2'b00, 32'd9, 32'd9);
        check("post_rst_c", 64'(bus.d), 64'd81);

        for (int i = 0; i < 16; i++) begin
            logic [XLEN-1:0] a;
            logic [XLEN-1:0] b;
            a = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
            b = (i % 5 == 0) ? 32'h7FFF_FFFF : $urandom;
            run_op("rand", 2'($urandom_range(0, 3)), a, b);
        end

        ack0 = bus.ack;
        d0   = bus.d;
        for (int i = 0; i < 100; i++) begin
            bus.n  = $urandom;
            bus.m  = $urandom;
            bus.op = 2'($urandom_range(0, 3));
            @(posedge sck);
            #1;
            check("idle_busy", 64'(bus.busy), 64'(0));
            check("idle_ack", 64'(bus.ack), 64'(ack0));
            check("idle_d", 64'(bus.d), 64'(d0));
        end

        @(negedge sck);
        check("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
